calc_in_seq: RTL

CALC_IN_SEQ -- requirements
Module: calc_in_seq

---
 rtl/calc_in_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/calc_in_seq.sv
// Two-beat operand sequencer in front of a combinational calculator core.
// Latency: beat 1 accepted at edge k -> out_valid during cycle k+2; 4-cycle minimum period.
// Backpressure: in_ready low during CALC/DONE; beats offered then are dropped, not queued.
module calc_in_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_data,
    input  logic [1:0] in_opt,
    output logic       in_ready,
    output logic [2:0] core_n0,
    output logic [2:0] core_n1,
    output logic [1:0] core_opt,
    input  logic [6:0] core_res,
    output logic       out_valid,
    output logic [6:0] out_data,
    output logic       err
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [1:0] OPT_BAD   = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_N1, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] n0_nxt, n1_nxt;
    logic [1:0] opt_nxt;
    logic [6:0] out_nxt;
    logic       err_nxt;
    logic       beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            core_n0  <= 3'd0;
            core_n1  <= 3'd0;
            core_opt <= 2'd0;
            out_data <= 7'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            core_n0  <= n0_nxt;
            core_n1  <= n1_nxt;
            core_opt <= opt_nxt;
            out_data <= out_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n0_nxt    = core_n0;
        n1_nxt    = core_n1;
        opt_nxt   = core_opt;
        out_nxt   = out_data;
        err_nxt   = 1'b0;
        in_ready  = (state == IDLE) || (state == WAIT_N1);
        out_valid = (state == DONE);
        beat      = in_valid && in_ready;

        case (state)
            IDLE: begin
                if (beat) begin
                    if (in_opt == OPT_BAD) begin
                        err_nxt = 1'b1;
                    end else begin
                        n0_nxt    = in_data;
                        opt_nxt   = in_opt;
                        cnt_nxt   = 8'd0;
                        state_nxt = WAIT_N1;
                    end
                end
            end
            WAIT_N1: begin
                if (beat) begin
                    n1_nxt    = in_data;
                    state_nxt = CALC;
                end else begin
                    // Saturate so a huge TIMEOUT can never wrap back to zero.
                    cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    if (cnt_nxt == TIMEOUT_C) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            CALC: begin
                out_nxt   = core_res;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
